// File: rtl/mo32_arb.sv
// Five-way round-robin burst arbiter merging 32-bit requester streams onto one
// registered output; the registered one-hot gnt is shared with the forward fan-out.
module mo32_arb #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [31:0] I4,
  input  logic [4:0]  req,
  input  logic [4:0]  last,
  output logic [4:0]  ack,
  output logic [31:0] O,
  output logic        o_valid,
  output logic        o_last,
  input  logic        o_ready,
  output logic [4:0]  gnt,
  output logic        to_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [4:0]      gnt_q, gnt_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic [31:0]     o_q, o_d;
  logic            o_valid_q, o_valid_d;
  logic            o_last_q, o_last_d;
  logic            to_err_q, to_err_d;

  logic [2:0]  pick;
  logic        pick_vld;
  logic [2:0]  next_ptr;
  logic [31:0] sel_data;
  logic        sel_last;
  logic        space;
  logic        beat;
  logic        expire;

  // Scan downward and overwrite so the first hit from ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = 3'd0;
    pick_vld = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % 5;
      if (req[idx]) begin
        pick     = 3'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = I0;
    unique case (owner_q)
      3'd0:    sel_data = I0;
      3'd1:    sel_data = I1;
      3'd2:    sel_data = I2;
      3'd3:    sel_data = I3;
      3'd4:    sel_data = I4;
      default: sel_data = I0;
    endcase
  end

  assign sel_last = last[owner_q];
  assign next_ptr = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
  assign space    = ~o_valid_q | o_ready;

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      owner_q   <= 3'd0;
      gnt_q     <= 5'd0;
      wdog_q    <= '0;
      o_q       <= 32'd0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      to_err_q  <= to_err_d;
    end
  end

  // FSM outputs: only the owner can be acked, and only when O has room.
  always_comb begin
    ack = 5'd0;
    if (state_q == StBusy && space) begin
      ack = gnt_q & req;
    end
  end

  assign beat   = |ack;
  assign expire = (state_q == StBusy) && !beat && (wdog_q == TO_W'(TIMEOUT - 1));

  // FSM next state, grant, watchdog and output register
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    to_err_d  = 1'b0;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;

    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (pick_vld) begin
          state_d = StBusy;
          owner_d = pick;
          gnt_d   = 5'd1 << pick;
        end
      end
      StBusy: begin
        if (beat) begin
          wdog_d = '0;
          if (sel_last) begin
            state_d = StIdle;
            gnt_d   = 5'd0;
            ptr_d   = next_ptr;
          end
        end else if (expire) begin
          state_d  = StIdle;
          gnt_d    = 5'd0;
          ptr_d    = next_ptr;
          wdog_d   = '0;
          to_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat) begin
      o_d       = sel_data;
      o_last_d  = sel_last;
      o_valid_d = 1'b1;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  assign O       = o_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign gnt     = gnt_q;
  assign to_err  = to_err_q;

endmodule
